// File: rtl/uart_receiver.sv
// 7E1 UART receiver: start, 7 data bits LSB first, even parity, stop; mid-bit sampling.
// Optional: define PARITY_CHECK_EN to report parity mismatches on parity_err (otherwise tied 0).
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [6:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MID_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_nxt;
  logic        rxd_meta, rxd_sync, rxd_prev;
  logic [1:0]  sync_fill;
  logic        armed;
  logic        fall;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [6:0]  shift_reg;
  logic        mid_hit, bit_hit, accept;

  // The synchronizer resets to 1s, so a line held low across reset would look like a
  // falling edge; edges only count once the line has been genuinely sampled high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rxd_prev  <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rxd_meta  <= rxd;
      rxd_sync  <= rxd_meta;
      rxd_prev  <= rxd_sync;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rxd_sync) armed <= 1'b1;
    end
  end

  assign fall    = armed && rxd_prev && !rxd_sync;
  assign mid_hit = (cnt == MID_LAST);
  assign bit_hit = (cnt == BIT_LAST);
  assign accept  = (state == STOP) && bit_hit && rxd_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (fall)    state_nxt = START;
      START:   if (mid_hit) state_nxt = rxd_sync ? IDLE : DATA;
      DATA:    if (bit_hit && bit_idx == 3'd6) state_nxt = PARITY;
      PARITY:  if (bit_hit) state_nxt = STOP;
      STOP:    if (bit_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE)                                cnt <= '0;
      else if ((state == START) ? mid_hit : bit_hit)   cnt <= '0;
      else                                              cnt <= cnt + 16'd1;

      if (state == START && mid_hit) bit_idx <= '0;

      if (state == DATA && bit_hit) begin
        shift_reg[bit_idx] <= rxd_sync;
        bit_idx            <= (bit_idx == 3'd6) ? 3'd0 : bit_idx + 3'd1;
      end

      if (accept) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
      end else if (state == STOP && bit_hit) begin
        frame_err  <= 1'b1;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  logic parity_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && bit_hit) parity_bit <= rxd_sync;
      if (accept)                     parity_err <= (^shift_reg) ^ parity_bit;
    end
  end
`else
  // The parity bit time is still walked through by the FSM; its value is simply ignored.
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5208, giving clk cycles per bit time (9600 baud at 50 MHz); legal range 4..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (low = reset).
REQ-004 The block SHALL have port rxd, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-005 The block SHALL have port data_out, output, 7 bits: last received data word.
REQ-006 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-007 The block SHALL have port parity_err, output, 1 bit: parity result of the last accepted frame; held until the next accepted frame.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 Frame format SHALL be: start bit (0), 7 data bits LSB first, even parity bit, stop bit (1); this is 10 bit times.
REQ-011 rxd SHALL pass through a two-flop synchronizer, reset value 1; all logic SHALL use only the synchronized value.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; reset state is IDLE.
REQ-013 IDLE->START SHALL occur on a synchronized 1->0 transition; the clock counter clears to 0.
REQ-014 In START, at count CLKS_PER_BIT/2-1 (mid-bit): if the line is 0, go to DATA with the counter cleared; if it is 1, go to IDLE (glitch, no flag).
REQ-015 DATA, PARITY and STOP SHALL each sample once at count CLKS_PER_BIT-1, then clear the counter; samples therefore fall at bit centres.
REQ-016 DATA SHALL shift the samples into bit index 0..6 using a 3-bit index, then go to PARITY after index 6.
REQ-017 PARITY SHALL capture the parity bit, then go to STOP.
REQ-018 STOP sample = 1: load data_out, update parity_err, pulse data_valid for exactly one cycle (the cycle after the sample), and go to IDLE.
REQ-019 STOP sample = 0: leave data_out and parity_err unchanged, pulse frame_err for one cycle, no data_valid, and go to IDLE.
REQ-020 A falling edge that arrives in the same cycle as the return to IDLE SHALL be detected; back-to-back frames SHALL be received without loss.
REQ-021 rxd activity while busy SHALL not restart the frame; only the FSM sequence governs it.
REQ-022 data_valid and frame_err SHALL never be high in the same cycle.
REQ-023 The clock counter SHALL be 16 bits, SHALL never exceed CLKS_PER_BIT-1 and SHALL hold 0 in IDLE.

Reset
REQ-024 Asserting reset at any time, including mid-frame, SHALL immediately set: state IDLE, counters 0, data_out 7'h00, data_valid 0, parity_err 0, frame_err 0, busy 0, synchronizer 1s.
REQ-025 After reset is released, a frame already in progress SHALL be ignored until the line is seen idle (1) and then falls.

Configuration
REQ-026 Macro PARITY_CHECK_EN defined: parity_err = (XOR of the 7 data bits) XOR (received parity bit), captured at acceptance per REQ-018.
REQ-027 PARITY_CHECK_EN undefined: the parity bit is still sampled for timing, but parity_err is constant 0; frame length is unchanged.

Verification (CLKS_PER_BIT=8, PARITY_CHECK_EN defined unless noted)
REQ-028 Send 7'h41 with parity 0 and stop 1 -> data_out=7'h41, one data_valid pulse, parity_err=0, busy low afterwards.
REQ-029 Send 7'h07 with parity 0 (wrong) -> data_out=7'h07, data_valid pulse, parity_err=1; then send a good 7'h55 with parity 0 -> parity_err=0.
REQ-030 Send 7'h2A with stop bit 0 -> frame_err pulse, no data_valid, data_out keeps its previous value.
REQ-031 Drive a 3-cycle low glitch on an idle line -> return to IDLE, no pulses; a following 7'h7F with parity 1 is received correctly.
REQ-032 Send back-to-back 7'h55 then 7'h2A with no idle gap -> two data_valid pulses, in order, both correct.
REQ-033 Assert reset at DATA index 3, release it while the line is low -> no output until the next full frame; with PARITY_CHECK_EN undefined, a bad-parity frame gives parity_err=0.
